// File: rtl/fp_divider_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring, one quotient bit per cycle,
// followed by a single rounding/exception cycle. Valid/ready on both sides.
module fp_divider_iter #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] a,
  input  logic [exp_width+mant_width-1:0] b,
  input  logic [2:0]                      round_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] out,
  output logic [4:0]                      exceptions
);
  localparam int W    = exp_width + mant_width;
  localparam int FW   = mant_width - 1;
  localparam int QW   = mant_width + 2;
  localparam int EW   = exp_width + 2;
  localparam int CW   = $clog2(QW);
  localparam int LW   = $clog2(mant_width + 1);
  localparam int BIAS = (1 << (exp_width - 1)) - 1;
  localparam int EMAX = (1 << exp_width) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {exp_width{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

  state_t                state;
  logic [W-1:0]          a_r, b_r;
  logic [2:0]            rm_r;
  logic [mant_width:0]   rem;
  logic [mant_width-1:0] sig_b_r;
  logic [QW-1:0]         q;
  logic signed [EW-1:0]  exp_q;
  logic                  sign_q;
  logic [CW-1:0]         count;
  logic                  special;
  logic [W-1:0]          spec_out;
  logic [4:0]            spec_exc;

  function automatic logic [LW-1:0] lzc(input logic [mant_width-1:0] v);
    logic [LW-1:0] n;
    n = LW'(mant_width);
    for (int i = 0; i < mant_width; i++)
      if (v[i]) n = LW'(mant_width - 1 - i);
    return n;
  endfunction

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic r;
    case (rm)
      3'b001:  r = 1'b0;
      3'b010:  r = sign & (g | s);
      3'b011:  r = ~sign & (g | s);
      3'b100:  r = g;
      default: r = g & (s | lsb);
    endcase
    return r;
  endfunction

  // Operand decode and subnormal left-normalisation
  logic [exp_width-1:0]  ea, eb;
  logic [FW-1:0]         fa, fb;
  logic [mant_width-1:0] sig_a_raw, sig_b_raw, sig_a_n, sig_b_n;
  logic [LW-1:0]         lz_a, lz_b;
  logic signed [EW-1:0]  ex_a, ex_b, exp_q_n;

  assign ea        = a_r[W-2:FW];
  assign eb        = b_r[W-2:FW];
  assign fa        = a_r[FW-1:0];
  assign fb        = b_r[FW-1:0];
  assign sig_a_raw = {ea != '0, fa};
  assign sig_b_raw = {eb != '0, fb};
  assign lz_a      = lzc(sig_a_raw);
  assign lz_b      = lzc(sig_b_raw);
  assign sig_a_n   = sig_a_raw << lz_a;
  assign sig_b_n   = sig_b_raw << lz_b;
  assign ex_a      = (ea == '0) ? EW'(1) - EW'(lz_a) : EW'(ea);
  assign ex_b      = (eb == '0) ? EW'(1) - EW'(lz_b) : EW'(eb);
  assign exp_q_n   = ex_a - ex_b + EW'(BIAS);

  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sign_x;
  logic is_spec;
  logic [W-1:0] spec_val;
  logic [4:0]   spec_flags;

  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_snan = a_nan & ~fa[FW-1];
  assign b_snan = b_nan & ~fb[FW-1];
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = (ea == '0) & (fa == '0);
  assign b_zero = (eb == '0) & (fb == '0);
  assign sign_x = a_r[W-1] ^ b_r[W-1];

  always_comb begin
    is_spec    = 1'b1;
    spec_val   = QNAN;
    spec_flags = 5'b00000;
    if (a_nan | b_nan)
      spec_flags = {a_snan | b_snan, 4'b0000};
    else if ((a_zero & b_zero) | (a_inf & b_inf))
      spec_flags = 5'b10000;
    else if (b_zero) begin
      spec_val   = {sign_x, {exp_width{1'b1}}, {FW{1'b0}}};
      spec_flags = 5'b01000;
    end else if (a_inf)
      spec_val = {sign_x, {exp_width{1'b1}}, {FW{1'b0}}};
    else if (a_zero | b_inf)
      spec_val = {sign_x, {(W-1){1'b0}}};
    else
      is_spec = 1'b0;
  end

  logic [mant_width+1:0] trial;
  assign trial = {1'b0, rem} - {2'b00, sig_b_r};

  // Rounding and exception generation on the finished quotient
  logic [QW-1:0]         q_adj;
  logic signed [EW-1:0]  exp_adj, e_fin;
  logic [EW-1:0]         sh;
  logic [QW:0]           ext, shifted, mask;
  logic [mant_width-1:0] mant;
  logic [mant_width:0]   mant_r;
  logic                  sticky, carry_u, tiny_rgn, tiny, g, s, inc, inexact, ovf, ovf_inf;
  logic [W-1:0]          rnd_out;
  logic [4:0]            rnd_exc;

  always_comb begin
    q_adj    = q[QW-1] ? q : {q[QW-2:0], 1'b0};
    exp_adj  = q[QW-1] ? exp_q : exp_q - EW'(1);
    sticky   = |rem;
    // Tininess after rounding: a result at the normal boundary that would carry
    // into the minimum normal under unbounded exponent range is not tiny.
    carry_u  = (&q_adj[QW-1:2]) & round_inc(rm_r, sign_q, q_adj[2], q_adj[1], q_adj[0] | sticky);
    tiny_rgn = (exp_adj <= 0);
    tiny     = (exp_adj < 0) | ((exp_adj == 0) & ~carry_u);
    sh       = '0;
    if (tiny_rgn) sh = EW'(1) - exp_adj;
    if (sh > EW'(QW + 1)) sh = EW'(QW + 1);
    ext      = {q_adj, sticky};
    shifted  = ext >> sh;
    mask     = ~({(QW+1){1'b1}} << sh);
    mant     = shifted[QW:3];
    g        = shifted[2];
    s        = shifted[1] | shifted[0] | (|(ext & mask));
    inexact  = g | s;
    inc      = round_inc(rm_r, sign_q, mant[0], g, s);
    mant_r   = {1'b0, mant} + {{mant_width{1'b0}}, inc};
    e_fin    = exp_adj + EW'(mant_r[mant_width]);
    ovf      = ~tiny_rgn & (e_fin >= EW'(EMAX));
    case (rm_r)
      3'b001:  ovf_inf = 1'b0;
      3'b010:  ovf_inf = sign_q;
      3'b011:  ovf_inf = ~sign_q;
      default: ovf_inf = 1'b1;
    endcase
    if (ovf)
      rnd_out = ovf_inf ? {sign_q, {exp_width{1'b1}}, {FW{1'b0}}}
                        : {sign_q, {(exp_width-1){1'b1}}, 1'b0, {FW{1'b1}}};
    else if (tiny_rgn)
      rnd_out = {sign_q, {(exp_width-1){1'b0}}, mant_r[FW:0]};
    else
      rnd_out = {sign_q, e_fin[exp_width-1:0], mant_r[FW-1:0]};
    rnd_exc = {2'b00, ovf, tiny & inexact, inexact | ovf};
  end

  assign in_ready = (state == IDLE);

  // Special operands skip the iterations by entering DIV on its last count,
  // which places their result at cycle 3.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      rm_r       <= '0;
      rem        <= '0;
      sig_b_r    <= '0;
      q          <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      count      <= '0;
      special    <= 1'b0;
      spec_out   <= '0;
      spec_exc   <= '0;
      out_valid  <= 1'b0;
      out        <= '0;
      exceptions <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          rm_r  <= round_mode;
          state <= NORM;
        end
        NORM: begin
          exp_q    <= exp_q_n;
          sign_q   <= sign_x;
          rem      <= {1'b0, sig_a_n};
          sig_b_r  <= sig_b_n;
          q        <= '0;
          special  <= is_spec;
          spec_out <= spec_val;
          spec_exc <= spec_flags;
          count    <= is_spec ? CW'(QW - 1) : '0;
          state    <= DIV;
        end
        DIV: begin
          if (trial[mant_width+1]) begin
            q   <= {q[QW-2:0], 1'b0};
            rem <= rem << 1;
          end else begin
            q   <= {q[QW-2:0], 1'b1};
            rem <= trial[mant_width:0] << 1;
          end
          if (count == CW'(QW - 1)) state <= ROUND;
          else count <= count + CW'(1);
        end
        ROUND: begin
          out        <= special ? spec_out : rnd_out;
          exceptions <= special ? spec_exc : rnd_exc;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_divider_iter.sv
// Self-checking bench for fp_divider_iter: table-driven directed vectors plus
// hand-written handshake, backpressure and reset-abort sequences.
module tb_fp_divider_iter;
  logic        clk, rst_l, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic [2:0]  round_mode;
  logic [4:0]  exceptions;
  int          checks, errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  exc;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  fp_divider_iter dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .exceptions(exceptions)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one operation, count cycles to out_valid and check the result.
  task automatic applyStimulus(input vec_t tv, input string tag, input bit release_out, input bit noisy);
    int cyc;
    bit busy_low;
    @(negedge clk);
    checkOutput($sformatf("%s_idle_ready", tag), {31'b0, in_ready}, 32'd1);
    a = tv.a; b = tv.b; round_mode = tv.rm; in_valid = 1'b1; out_ready = release_out;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    busy_low = 1'b1;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_low = 1'b0;
      if (noisy && cyc < 10) begin
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h00000000; round_mode = 3'b011;
      end else
        in_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (in_ready) busy_low = 1'b0;
    checkOutput($sformatf("%s_latency", tag), 32'(cyc), 32'(tv.lat));
    checkOutput($sformatf("%s_out", tag), out, tv.res);
    checkOutput($sformatf("%s_exc", tag), {27'b0, exceptions}, {27'b0, tv.exc});
    checkOutput($sformatf("%s_busy_ready_low", tag), {31'b0, busy_low}, 32'd1);
    if (release_out) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s_valid_cleared", tag), {31'b0, out_valid}, 32'd0);
      checkOutput($sformatf("%s_ready_back", tag), {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_l = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; round_mode = '0;

    vecs.push_back('{32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'h00, 28});
    vecs.push_back('{32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'h01, 28});
    vecs.push_back('{32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 5'h01, 28});
    vecs.push_back('{32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 5'h08, 3});
    vecs.push_back('{32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 5'h10, 3});
    vecs.push_back('{32'h7F7FFFFF, 32'h00800000, 3'b000, 32'h7F800000, 5'h05, 28});
    vecs.push_back('{32'h7F7FFFFF, 32'h00800000, 3'b001, 32'h7F7FFFFF, 5'h05, 28});
    vecs.push_back('{32'hFF7FFFFF, 32'h00800000, 3'b010, 32'hFF800000, 5'h05, 28});
    vecs.push_back('{32'hFF7FFFFF, 32'h00800000, 3'b011, 32'hFF7FFFFF, 5'h05, 28});
    vecs.push_back('{32'h7F800000, 32'h40000000, 3'b000, 32'h7F800000, 5'h00, 3});
    vecs.push_back('{32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'h10, 3});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 3'b000, 32'h7FC00000, 5'h00, 3});
    vecs.push_back('{32'hBF800000, 32'h7F800000, 3'b000, 32'h80000000, 5'h00, 3});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 5'h10, 3});
    vecs.push_back('{32'hC0C00000, 32'h40000000, 3'b000, 32'hC0400000, 5'h00, 28});
    vecs.push_back('{32'h00800000, 32'h40000000, 3'b000, 32'h00400000, 5'h00, 28});
    vecs.push_back('{32'h00000001, 32'h40000000, 3'b000, 32'h00000000, 5'h03, 28});
    vecs.push_back('{32'h00000001, 32'h40000000, 3'b011, 32'h00000001, 5'h03, 28});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 3'b001, 32'h3F800000, 5'h00, 28});
    vecs.push_back('{32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 5'h01, 28});
    vecs.push_back('{32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 5'h01, 28});
    vecs.push_back('{32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 5'h01, 28});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out", out, 32'd0);
    checkOutput("rst_exc", {27'b0, exceptions}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk) rst_l = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i), 1'b1, 1'b0);

    // in_valid with other operands while busy must not disturb the result
    applyStimulus(vecs[0], "noisy", 1'b1, 1'b1);

    // Backpressure: result held while out_ready stays low
    v = '{32'h00000001, 32'h3F800000, 3'b000, 32'h00000001, 5'h00, 28};
    applyStimulus(v, "bp", 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold_valid%0d", k), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_out%0d", k), out, 32'h00000001);
      checkOutput($sformatf("bp_hold_exc%0d", k), {27'b0, exceptions}, 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(vecs[1], "after_bp", 1'b1, 1'b0);

    // Reset pulse in the middle of the iterations aborts the operation
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; round_mode = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk) rst_l = 1'b1;
    applyStimulus(vecs[0], "post_midrst", 1'b1, 1'b0);

    // Reset while a result is waiting in DONE drops it immediately
    applyStimulus(vecs[3], "done_rst", 1'b0, 1'b0);
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("donerst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("donerst_out", out, 32'd0);
    checkOutput("donerst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_l = 1'b1;
    out_ready = 1'b1;
    applyStimulus(vecs[2], "post_donerst", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
